// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants and types for the UART transmitter and receiver.
//   UART_DATA_BITS     : data bits per frame (8N1 framing)
//   UART_CLKS_PER_BIT  : default clocks per bit (100 MHz / 115200 baud)
//   uart_state_e       : receiver FSM states
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned UART_DATA_BITS    = 8;
    localparam int unsigned UART_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// ---------------------------------------------------------------------------
// uart_sync2
// Two-flop synchronizer for a single asynchronous input.
//   i_clk : destination clock
//   i_rst : synchronous active-high reset; both flops load RESET_VAL
//   i_d   : asynchronous input
//   o_q   : synchronized output, two cycles behind i_d
// ---------------------------------------------------------------------------
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver. Synchronizes the serial line, samples each bit at its
// midpoint and holds the received byte behind a valid/ready handshake.
//   CLKS_PER_BIT : clocks per bit period; must be >= 4 and even
//   clk          : system clock
//   rst          : synchronous active-high reset; aborts any frame in flight
//   rx_in        : asynchronous serial line, idles high
//   rx_ready     : consumer takes the held byte when rx_valid && rx_ready
//   rx_data      : held byte, stable while rx_valid is high
//   rx_valid     : a byte is held and not yet consumed
//   rx_busy      : receiver is anywhere other than idle
//   rx_frame_err : one-cycle pulse, stop bit sampled low
//   rx_overrun   : one-cycle pulse, byte completed while the previous one
//                  was still held (new byte is dropped)
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       BIT_LAST  = 3'(UART_DATA_BITS - 1);

    logic        w_rx_s;

    uart_state_e r_state;
    uart_state_e w_state_nxt;
    logic [CNT_W-1:0] r_baud;
    logic [CNT_W-1:0] w_baud_nxt;
    logic [2:0]  r_bit;
    logic [2:0]  w_bit_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic [7:0]  r_data;
    logic [7:0]  w_data_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic        r_frame_err;
    logic        w_frame_err_nxt;
    logic        r_overrun;
    logic        w_overrun_nxt;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (rx_in),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_baud      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_baud      <= w_baud_nxt;
            r_bit       <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_baud_nxt      = r_baud;
        w_bit_nxt       = r_bit;
        w_shift_nxt     = r_shift;
        w_data_nxt      = r_data;
        w_valid_nxt     = r_valid;
        w_frame_err_nxt = 1'b0;
        w_overrun_nxt   = 1'b0;

        // Consumer handshake is resolved before any byte completion so a byte
        // finishing in the same cycle lands in the freshly emptied holder.
        if (r_valid && rx_ready) begin
            w_valid_nxt = 1'b0;
        end

        case (r_state)
            StIdle: begin
                if (!w_rx_s) begin
                    w_state_nxt = StStart;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                end
            end

            StStart: begin
                // Half a bit in, the start bit must still be low; otherwise
                // the falling edge was a glitch.
                if (r_baud == HALF_LAST) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = w_rx_s ? StIdle : StData;
                end else begin
                    w_baud_nxt = r_baud + CNT_W'(1);
                end
            end

            StData: begin
                if (r_baud == FULL_LAST) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {w_rx_s, r_shift[7:1]};
                    if (r_bit == BIT_LAST) begin
                        w_state_nxt = StStop;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud + CNT_W'(1);
                end
            end

            StStop: begin
                if (r_baud == FULL_LAST) begin
                    w_baud_nxt = '0;
                    if (w_rx_s) begin
                        w_state_nxt = StIdle;
                        if (w_valid_nxt) begin
                            w_overrun_nxt = 1'b1;
                        end else begin
                            w_data_nxt  = r_shift;
                            w_valid_nxt = 1'b1;
                        end
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = StBreak;
                    end
                end else begin
                    w_baud_nxt = r_baud + CNT_W'(1);
                end
            end

            StBreak: begin
                // Hold off until the line recovers so a stuck-low line does
                // not look like an endless stream of start bits.
                if (w_rx_s) begin
                    w_state_nxt = StIdle;
                end
            end

            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign rx_busy      = (r_state != StIdle);
    assign rx_frame_err = r_frame_err;
    assign rx_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx with CLKS_PER_BIT = 8.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 8;

    logic       clk;
    logic       rst;
    logic       rx_in;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       rx_frame_err;
    logic       rx_overrun;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int start_cyc = 0;

    // Monitor counters only ever increase; tests compare deltas.
    int         rise_n   = 0;
    int         rise_cyc = 0;
    logic [7:0] rise_data = 8'h00;
    int         valid_hi_n = 0;
    int         busy_n   = 0;
    int         ferr_n   = 0;
    int         ovr_n    = 0;
    logic       prev_valid = 1'b0;

    int b_rise;
    int b_valid_hi;
    int b_busy;
    int b_ferr;
    int b_ovr;

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_in        (rx_in),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_busy      (rx_busy),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_valid <= rx_valid;
        if (rx_valid === 1'b1 && prev_valid !== 1'b1) begin
            rise_n    <= rise_n + 1;
            rise_cyc  <= cyc;
            rise_data <= rx_data;
        end
        if (rx_valid === 1'b1)     valid_hi_n <= valid_hi_n + 1;
        if (rx_busy === 1'b1)      busy_n     <= busy_n + 1;
        if (rx_frame_err === 1'b1) ferr_n     <= ferr_n + 1;
        if (rx_overrun === 1'b1)   ovr_n      <= ovr_n + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_rise     = rise_n;
        b_valid_hi = valid_hi_n;
        b_busy     = busy_n;
        b_ferr     = ferr_n;
        b_ovr      = ovr_n;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives the first 'slots' bit slots of an 8N1 frame (start, d0..d7, stop).
    task automatic drive_frame(input logic [7:0] b, input logic stop, input int slots);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        @(posedge clk);
        #1;
        start_cyc = cyc;
        for (int i = 0; i < slots; i++) begin
            rx_in = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst      = 1'b1;
        rx_in    = 1'b1;
        rx_ready = 1'b0;
        idle(4);
        rst = 1'b0;

        // Reset state and quiet idle line
        snap();
        idle(200);
        check_eq("reset_data", {24'd0, rx_data}, 32'h00);
        check_eq("reset_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("reset_busy", {31'd0, rx_busy}, 32'd0);
        check_eq("reset_ferr", {31'd0, rx_frame_err}, 32'd0);
        check_eq("reset_ovr", {31'd0, rx_overrun}, 32'd0);
        check_eq("idle_busy_cycles", busy_n - b_busy, 32'd0);

        // Single byte with consumer ready
        rx_ready = 1'b1;
        snap();
        drive_frame(8'hA5, 1'b1, 10);
        idle(5);
        check_eq("a5_rise_count", rise_n - b_rise, 32'd1);
        check_eq("a5_data", {24'd0, rise_data}, 32'hA5);
        check_eq("a5_latency", rise_cyc - start_cyc, 32'd79);
        check_eq("a5_valid_width", valid_hi_n - b_valid_hi, 32'd1);
        check_eq("a5_busy_cycles", busy_n - b_busy, 32'd76);
        check_eq("a5_ferr", ferr_n - b_ferr, 32'd0);
        check_eq("a5_ovr", ovr_n - b_ovr, 32'd0);

        // Back-to-back frames with consumer stalled -> overrun on the second
        rx_ready = 1'b0;
        snap();
        drive_frame(8'h3C, 1'b1, 10);
        drive_frame(8'hC3, 1'b1, 10);
        idle(5);
        check_eq("ovr_valid_held", {31'd0, rx_valid}, 32'd1);
        check_eq("ovr_data_kept", {24'd0, rx_data}, 32'h3C);
        check_eq("ovr_pulses", ovr_n - b_ovr, 32'd1);
        check_eq("ovr_rise_count", rise_n - b_rise, 32'd1);
        check_eq("ovr_ferr", ferr_n - b_ferr, 32'd0);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        check_eq("ovr_consumed", {31'd0, rx_valid}, 32'd0);

        // Framing error, line held low, then recovery
        rx_ready = 1'b1;
        snap();
        drive_frame(8'hFF, 1'b0, 10);
        idle(40);
        check_eq("brk_busy_held", {31'd0, rx_busy}, 32'd1);
        check_eq("brk_ferr_pulses", ferr_n - b_ferr, 32'd1);
        check_eq("brk_no_valid", rise_n - b_rise, 32'd0);
        rx_in = 1'b1;
        idle(5);
        check_eq("brk_busy_released", {31'd0, rx_busy}, 32'd0);
        snap();
        drive_frame(8'h55, 1'b1, 10);
        idle(5);
        check_eq("post_brk_rise", rise_n - b_rise, 32'd1);
        check_eq("post_brk_data", {24'd0, rise_data}, 32'h55);
        check_eq("post_brk_ferr", ferr_n - b_ferr, 32'd0);

        // Glitch shorter than half a bit
        snap();
        idle(1);
        rx_in = 1'b0;
        idle(3);
        rx_in = 1'b1;
        idle(30);
        check_eq("glitch_busy_cycles", busy_n - b_busy, 32'd4);
        check_eq("glitch_no_valid", rise_n - b_rise, 32'd0);
        check_eq("glitch_no_ferr", ferr_n - b_ferr, 32'd0);
        check_eq("glitch_no_ovr", ovr_n - b_ovr, 32'd0);
        check_eq("glitch_idle", {31'd0, rx_busy}, 32'd0);

        // Reset in the middle of data bit 4
        snap();
        drive_frame(8'h81, 1'b1, 5);
        rx_in = 1'b0;
        idle(4);
        check_eq("mid_frame_busy", {31'd0, rx_busy}, 32'd1);
        rst   = 1'b1;
        rx_in = 1'b1;
        idle(1);
        check_eq("abort_busy", {31'd0, rx_busy}, 32'd0);
        check_eq("abort_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("abort_data", {24'd0, rx_data}, 32'h00);
        rst = 1'b0;
        idle(20);
        check_eq("abort_no_flags", (ferr_n - b_ferr) + (ovr_n - b_ovr), 32'd0);
        snap();
        drive_frame(8'h81, 1'b1, 10);
        idle(5);
        check_eq("post_abort_rise", rise_n - b_rise, 32'd1);
        check_eq("post_abort_data", {24'd0, rise_data}, 32'h81);
        check_eq("post_abort_latency", rise_cyc - start_cyc, 32'd79);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
